// File: rtl/tty_uart_tx.sv
// Buffered 8N1 serial transmitter: bytes written into a circular FIFO are sent LSB first.
// Exactly one byte leaves the FIFO on each IDLE->START transition.
module tty_uart_tx #(
    parameter int DEPTH        = 16,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    write,
    input  logic [7:0]              write_data,
    output logic                    full,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    tx,
    output logic                    busy,
    output logic                    overflow,
    output logic [1:0]              state_dbg
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_overflow;
    state_t        r_state;
    logic [CW-1:0] r_clk_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic          r_tx;

    state_t        w_state_next;
    logic [CW-1:0] w_clk_next;
    logic [2:0]    w_idx_next;
    logic [7:0]    w_shift_next;
    logic          w_tx_next;
    logic          w_pop;
    logic          w_push;
    logic          w_full;
    logic          w_bit_end;

    assign w_full    = (r_count == FULL_CNT);
    assign w_push    = write && !w_full;
    assign w_bit_end = (r_clk_cnt == LAST_CLK);

    always_comb begin
        w_state_next = r_state;
        w_clk_next   = r_clk_cnt;
        w_idx_next   = r_bit_idx;
        w_shift_next = r_shift;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_pop        = 1'b1;
                    w_shift_next = r_mem[r_rd_ptr];
                    w_clk_next   = '0;
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_clk_next   = '0;
                    w_idx_next   = 3'd0;
                    w_state_next = S_DATA;
                end else begin
                    w_clk_next = r_clk_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_clk_next   = '0;
                    w_shift_next = {1'b0, r_shift[7:1]};
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = S_STOP;
                    end else begin
                        w_idx_next = r_bit_idx + 1'b1;
                    end
                end else begin
                    w_clk_next = r_clk_cnt + 1'b1;
                end
            end
            default: begin
                if (w_bit_end) begin
                    w_clk_next   = '0;
                    w_state_next = S_IDLE;
                end else begin
                    w_clk_next = r_clk_cnt + 1'b1;
                end
            end
        endcase
        // The line level is decided from the next state so tx itself is a flop.
        case (w_state_next)
            S_START: w_tx_next = 1'b0;
            S_DATA:  w_tx_next = w_shift_next[0];
            default: w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_clk_cnt  <= '0;
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'd0;
            r_tx       <= 1'b1;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_clk_cnt <= w_clk_next;
            r_bit_idx <= w_idx_next;
            r_shift   <= w_shift_next;
            r_tx      <= w_tx_next;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (write && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage has no reset; the pointers and count define which entries are valid.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= write_data;
        end
    end

    assign full      = w_full;
    assign count     = r_count;
    assign tx        = r_tx;
    assign busy      = (r_state != S_IDLE);
    assign overflow  = r_overflow;
    assign state_dbg = r_state;

endmodule

// File: tb/tb_tty_uart_tx.sv
// Bench for tty_uart_tx: timing-level reference model plus a line decoder.
// Every accepted byte gets a predicted pop edge; status outputs are checked every cycle.
module tb_tty_uart_tx;
  localparam int DEPTH = 16;
  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       write = 1'b0;
  logic [7:0] write_data = 8'h00;
  logic       full;
  logic [4:0] count;
  logic       tx;
  logic       busy;
  logic       overflow;
  logic [1:0] state_dbg;

  tty_uart_tx #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
    .clock      (clock),
    .reset      (reset),
    .write      (write),
    .write_data (write_data),
    .full       (full),
    .count      (count),
    .tx         (tx),
    .busy       (busy),
    .overflow   (overflow),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / edge counter ----------------
  always #5 clock = ~clock;

  int pos_cnt = 0;
  always @(posedge clock) pos_cnt <= pos_cnt + 1;

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  int         pop_q[$];
  int         acc_e[$];
  int         pop_e[$];
  int         start_q[$];
  int         last_pop = -1000;
  int         ovf_edge = 32'h7fffffff;
  int         n_cmp = 0;
  int         n_err = 0;
  int         rx_total = 0;
  int         n_unexp = 0;
  bit         chk_en = 1'b0;
  bit         rst_seen = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at edge %0d", tag, got, exp, pos_cnt);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int m_count(input int e);
    int n = 0;
    foreach (acc_e[i]) if (acc_e[i] <= e && pop_e[i] > e) n++;
    return n;
  endfunction

  function automatic bit m_busy(input int e);
    foreach (pop_e[i]) if (pop_e[i] <= e && e < pop_e[i] + FRAME) return 1'b1;
    return 1'b0;
  endfunction

  // A write sampled at edge e sees the occupancy left by edge e-1.
  task automatic model_write(input int e, input logic [7:0] d);
    int p;
    if (m_count(e - 1) == DEPTH) begin
      if (ovf_edge > e) ovf_edge = e;
    end else begin
      p = (e + 1 > last_pop + FRAME + 1) ? e + 1 : last_pop + FRAME + 1;
      acc_e.push_back(e);
      pop_e.push_back(p);
      last_pop = p;
      exp_q.push_back(d);
      pop_q.push_back(p);
    end
  endtask

  task automatic model_clear();
    acc_e.delete();
    pop_e.delete();
    exp_q.delete();
    pop_q.delete();
    last_pop = -1000;
    ovf_edge = 32'h7fffffff;
  endtask

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic push(input logic [7:0] d);
    write      = 1'b1;
    write_data = d;
    model_write(pos_cnt + 1, d);
    @(negedge clock);
    write      = 1'b0;
    write_data = 8'($urandom_range(0, 255));
  endtask

  task automatic do_reset();
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("rst_tx", tx, 1);
    check("rst_count", count, 0);
    check("rst_busy", busy, 0);
    check("rst_full", full, 0);
    check("rst_overflow", overflow, 0);
    model_clear();
    repeat (3) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || m_busy(pos_cnt)) && n < 20000) begin
      @(negedge clock);
      n++;
    end
    check("drain_left", exp_q.size(), 0);
    repeat (3) @(negedge clock);
  endtask

  always @(posedge reset) rst_seen = 1'b1;

  // ---------------- per-cycle status checker ----------------
  always @(negedge clock) begin
    if (chk_en && !reset) begin
      check("count", count, m_count(pos_cnt));
      check("full", full, m_count(pos_cnt) == DEPTH);
      check("busy", busy, m_busy(pos_cnt));
      check("overflow", overflow, ovf_edge <= pos_cnt);
      if (!m_busy(pos_cnt)) begin
        check("tx_idle", tx, 1);
        check("state_idle", state_dbg, 0);
      end
    end
  end

  // ---------------- line decoder ----------------
  initial begin : line_mon
    logic [9:0] bits;
    int st;
    bits = '0;
    forever begin
      @(negedge clock);
      if (!reset && tx === 1'b0) begin
        st = pos_cnt;
        rst_seen = 1'b0;
        for (int j = 0; j < 10; j++) begin
          repeat ((j == 0) ? CPB / 2 : CPB) @(negedge clock);
          bits[j] = tx;
        end
        if (!rst_seen) begin
          check("start_bit", bits[0], 0);
          check("stop_bit", bits[9], 1);
          rx_total++;
          start_q.push_back(st);
          if (exp_q.size() > 0) begin
            check("frame_data", bits[8:1], exp_q.pop_front());
            check("frame_start", st, pop_q.pop_front());
          end else begin
            n_unexp++;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int rx_before;
    int guard;
    #1 reset = 1'b1;
    repeat (3) @(negedge clock);
    check("init_tx", tx, 1);
    check("init_count", count, 0);
    check("init_overflow", overflow, 0);
    reset  = 1'b0;
    chk_en = 1'b1;

    // quiet line after reset
    repeat (100) @(negedge clock);

    // single byte 'A'
    push(8'h41);
    check("t2_count_one", count, 1);
    @(negedge clock);
    check("t2_count_zero", count, 0);
    check("t2_tx_start", tx, 0);
    wait_drain();

    // back-to-back "Hi\n"
    start_q.delete();
    push(8'h48);
    push(8'h69);
    push(8'h0A);
    wait_drain();
    check("t3_frames", start_q.size(), 3);
    if (start_q.size() == 3) begin
      check("t3_gap1", start_q[1] - start_q[0], FRAME + 1);
      check("t3_gap2", start_q[2] - start_q[1], FRAME + 1);
    end

    // full and overflow: 18 consecutive bytes
    for (int i = 0; i < 18; i++) push(8'(i));
    check("t4_full", full, 1);
    check("t4_count", count, DEPTH);
    check("t4_overflow", overflow, 1);
    wait_drain();
    check("t4_overflow_sticky", overflow, 1);
    do_reset();
    @(negedge clock);
    check("t4_overflow_cleared", overflow, 0);

    // wrap-around with random spacing; never write into a full FIFO
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 40)) @(negedge clock);
      guard = 0;
      while (m_count(pos_cnt) >= DEPTH && guard < 5000) begin
        @(negedge clock);
        guard++;
      end
      push(8'($urandom_range(0, 255)));
    end
    wait_drain();
    check("t5_no_overflow", overflow, 0);

    // reset mid-frame during data bit 3
    push(8'h5A);
    push(8'($urandom_range(0, 255)));
    push(8'($urandom_range(0, 255)));
    repeat (15) @(negedge clock);
    check("t6_queued", count, 2);
    check("t6_busy", busy, 1);
    rx_before = rx_total;
    do_reset();
    repeat (100) @(negedge clock);
    check("t6_silent", rx_total - rx_before, 0);
    push(8'h31);
    wait_drain();
    check("t6_one_frame", rx_total - rx_before, 1);

    check("unexpected_frames", n_unexp, 0);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
